// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches
// that drive the 1010 detector path.
package seq_pkg;

    // Transmitter FSM encoding; values are fixed so waveforms read the same everywhere.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Canonical stimulus pattern used by the detector benches.
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_tx_shifter.sv
// Frame shift register: holds the pattern of the frame being sent, MSB
// aligned with the bit currently on the line, plus a down-counting bit
// index so the controller knows when the final bit of a frame is out.
module seq_tx_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             next_bit,
    output logic             last_bit
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] sr_reg;
    logic [IDX_W-1:0] idx_reg;

    // Load a fresh frame or advance one bit; load wins when both are requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg  <= '0;
            idx_reg <= '0;
        end else if (load) begin
            sr_reg  <= load_val;
            idx_reg <= IDX_W'(PAT_W - 1);
        end else if (shift) begin
            sr_reg  <= {sr_reg[PAT_W-2:0], 1'b0};
            idx_reg <= idx_reg - IDX_W'(1);
        end
    end

    // The bit that follows the one currently on the line.
    assign next_bit = sr_reg[PAT_W-2];
    // The bit currently on the line is the frame's LSB.
    assign last_bit = (idx_reg == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for a
// programmed number of frames, with optional idle gaps between frames.
// Every output is a register computed from the next state, so dout and
// dout_valid line up with the cycle the FSM is actually in.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    state_t           state_reg, state_next;
    logic [PAT_W-1:0] pattern_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [CNT_W-1:0] frames_left_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             dout_reg, dout_valid_reg, busy_reg, done_reg;

    logic             capture, load, shift, frame_inc, gap_load, gap_dec;
    logic             dout_next;
    logic [PAT_W-1:0] load_val;
    logic             next_bit, last_bit;

    // On an accepted start the shifter must see the live input, not the stale capture.
    assign load_val = capture ? pattern : pattern_reg;

    seq_tx_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .load_val (load_val),
        .next_bit (next_bit),
        .last_bit (last_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state decode plus the datapath strobes and the next line bit.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        frame_inc  = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        dout_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    capture = 1'b1;
                    if (repeat_cnt == '0) begin
                        state_next = FIN;
                    end else begin
                        state_next = SHIFT;
                        load       = 1'b1;
                        dout_next  = pattern[PAT_W-1];
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = FIN;
                end else if (last_bit) begin
                    frame_inc = 1'b1;
                    if (frames_left_reg == CNT_W'(1)) begin
                        state_next = FIN;
                    end else if (gap_reg == '0) begin
                        // Back-to-back frame: next MSB with no bubble.
                        load      = 1'b1;
                        dout_next = pattern_reg[PAT_W-1];
                    end else begin
                        state_next = GAP;
                        gap_load   = 1'b1;
                    end
                end else begin
                    shift     = 1'b1;
                    dout_next = next_bit;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = FIN;
                end else if (gap_cnt_reg == GAP_W'(1)) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                    dout_next  = pattern_reg[PAT_W-1];
                end else begin
                    gap_dec = 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job parameters, frame accounting and gap timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_reg     <= '0;
            gap_reg         <= '0;
            frames_left_reg <= '0;
            frame_cnt_reg   <= '0;
            gap_cnt_reg     <= '0;
        end else begin
            if (capture) begin
                pattern_reg     <= pattern;
                gap_reg         <= gap_len;
                frames_left_reg <= repeat_cnt;
                frame_cnt_reg   <= '0;
            end else if (frame_inc) begin
                frames_left_reg <= frames_left_reg - CNT_W'(1);
                frame_cnt_reg   <= frame_cnt_reg + CNT_W'(1);
            end
            if (gap_load)     gap_cnt_reg <= gap_reg;
            else if (gap_dec) gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            dout_reg       <= dout_next;
            dout_valid_reg <= (state_next == SHIFT);
            busy_reg       <= (state_next != IDLE);
            done_reg       <= (state_next == FIN);
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one task per scenario, each with its
// own hand-derived expectations.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic [7:0] repeat_cnt = 8'd0;
    logic [3:0] gap_len = 4'd0;
    logic       dout, dout_valid, busy, done;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request for one edge.
    task automatic start_job(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
        pattern    = p;
        repeat_cnt = r;
        gap_len    = g;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({dout, dout_valid, busy, done, frame_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%b valid=%b busy=%b done=%b frame_cnt=%0d, want all 0",
                     dout, dout_valid, busy, done, frame_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, dout_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b valid=%b, want 000", busy, done, dout_valid);
        end
        $display("reset: released, idle");
    endtask

    task automatic test_single();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;
        start_job(DEFAULT_PATTERN, 8'd1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_bits[3-i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_bit%0d: got valid=%b dout=%b busy=%b, want valid=1 dout=%b busy=1",
                         i, dout_valid, dout, busy, exp_bits[3-i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || dout !== 1'b0 || busy !== 1'b1 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_fin: got done=%b valid=%b dout=%b busy=%b frame_cnt=%0d, want 1 0 0 1 1",
                     done, dout_valid, dout, busy, frame_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_idle: got done=%b busy=%b frame_cnt=%0d, want 0 0 1", done, busy, frame_cnt);
        end
        $display("single: pattern 1010 x1 gap 0 frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_back_to_back();
        logic [3:0] hist;
        int         seen, hits;
        hist = 4'b0000;
        seen = 0;
        hits = 0;
        start_job(4'b1010, 8'd3, 4'd0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_bit%0d: got valid=%b dout=%b, want valid=1 dout=%b",
                         i, dout_valid, dout, ((i % 2) == 0));
            end
            if (dout_valid === 1'b1) begin
                hist = {hist[2:0], dout};
                seen++;
                if (seen >= 4 && hist == 4'b1010) hits++;
            end
            tick();
        end
        checks++;
        if (hits != 5) begin
            errors++;
            $display("FAIL b2b_detections: got %0d, want 5", hits);
        end
        checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || frame_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_fin: got done=%b valid=%b frame_cnt=%0d, want 1 0 3", done, dout_valid, frame_cnt);
        end
        tick();
        $display("back_to_back: 12 bits, detections=%0d frame_cnt=%0d", hits, frame_cnt);
    endtask

    task automatic test_gap();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;
        start_job(4'b1010, 8'd2, 4'd3);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (i >= 4 && i < 7) begin
                if (dout_valid !== 1'b0 || dout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_idle%0d: got valid=%b dout=%b busy=%b, want 0 0 1",
                             i - 4, dout_valid, dout, busy);
                end
            end else begin
                if (dout_valid !== 1'b1 || dout !== exp_bits[3 - (i % 7 % 4)]) begin
                    errors++;
                    $display("FAIL gap_bit%0d: got valid=%b dout=%b, want valid=1 dout=%b",
                             i, dout_valid, dout, exp_bits[3 - (i % 7 % 4)]);
                end
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || frame_cnt !== 8'd2 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_fin: got done=%b frame_cnt=%0d valid=%b, want 1 2 0", done, frame_cnt, dout_valid);
        end
        tick();
        $display("gap: 1010 x2 gap 3 frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_zero_repeat();
        start_job(4'b1111, 8'd0, 4'd2);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || dout_valid !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL zero_fin: got done=%b busy=%b valid=%b frame_cnt=%0d, want 1 1 0 0",
                     done, busy, dout_valid, frame_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got done=%b busy=%b valid=%b, want 0 0 0", done, busy, dout_valid);
        end
        $display("zero_repeat: done pulse only, frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_abort();
        start_job(4'b1010, 8'd4, 4'd0);
        // Stream indices 0..8 cover frames 1, 2 and the first bit of frame 3.
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 1'b0 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL abort_pre: got valid=%b dout=%b frame_cnt=%0d, want 1 0 2", dout_valid, dout, frame_cnt);
        end
        tick();
        abort = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || done !== 1'b1 || frame_cnt !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_fin: got valid=%b done=%b frame_cnt=%0d busy=%b, want 0 1 2 1",
                     dout_valid, done, frame_cnt, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL abort_idle: got done=%b busy=%b frame_cnt=%0d, want 0 0 2", done, busy, frame_cnt);
        end
        // Abort together with start in IDLE rejects the start.
        abort = 1'b1;
        start_job(4'b1111, 8'd5, 4'd0);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL abort_start_idle: got busy=%b done=%b valid=%b frame_cnt=%0d, want 0 0 0 2",
                     busy, done, dout_valid, frame_cnt);
        end
        tick();
        $display("abort: stopped in frame 3, frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_busy_start_and_rst();
        start_job(4'b1100, 8'd2, 4'd1);
        tick();
        // Second start mid-frame with different parameters must be ignored.
        start_job(4'b0011, 8'd1, 4'd0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_bit2: got valid=%b dout=%b, want 1 0", dout_valid, dout);
        end
        tick();
        tick();
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b1 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL busy_start_gap: got valid=%b busy=%b frame_cnt=%0d, want 0 1 1", dout_valid, busy, frame_cnt);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_frame2: got valid=%b dout=%b, want 1 1 (original pattern kept)", dout_valid, dout);
        end
        // Asynchronous reset mid-SHIFT, asserted away from any edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout, dout_valid, busy, done, frame_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL async_rst: got dout=%b valid=%b busy=%b done=%b frame_cnt=%0d, want all 0",
                     dout, dout_valid, busy, done, frame_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        start_job(4'b1000, 8'd1, 4'd0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_start: got valid=%b dout=%b busy=%b, want 1 1 1", dout_valid, dout, busy);
        end
        for (int i = 0; i < 5; i++) tick();
        $display("busy_start_and_rst: start ignored, reset cleared outputs");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_zero_repeat();
        test_abort();
        test_busy_start_and_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
